// File: rtl/if_id_stage_if.sv
// Fetch-to-decode handshake bundle: inbound beats, flush, head beat and its pre-split fields.
interface if_id_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc4;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_pc4;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] jump_target;
  logic [CNT_W-1:0]  stall_cnt;

  // master: the fetch/decode environment around the stage
  modport master (
    output in_valid, in_instr, in_pc4, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc4, opcode, rs, rt, rd,
           shamt, funct, imm_sext, jump_target, stall_cnt
  );

  // slave: the stage itself
  modport slave (
    input  in_valid, in_instr, in_pc4, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc4, opcode, rs, rt, rd,
           shamt, funct, imm_sext, jump_target, stall_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: 2-entry skid buffer, latency 1, in_ready drops only when both entries hold beats.
// Head beat is presented with MIPS fields, sign-extended immediate and jump target decoded combinationally.
module if_id_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  if_id_stage_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] e0_instr, e0_pc4;
  logic [DATA_W-1:0] e1_instr, e1_pc4;
  logic              in_xfer, out_xfer;
  logic              ld0_new, ld0_shift, ld1_new;
  logic              stall_inc;
  logic [DATA_W-1:0] head_instr, head_pc4;

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign in_xfer       = bus.in_valid & bus.in_ready;
  assign out_xfer      = bus.out_valid & bus.out_ready;
  assign stall_inc     = bus.out_valid & ~bus.out_ready & ~bus.flush;

  always_comb begin
    state_nxt = state;
    ld0_new   = 1'b0;
    ld0_shift = 1'b0;
    ld1_new   = 1'b0;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt = ONE;
            ld0_new   = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            ld0_new = 1'b1;
          end else if (in_xfer) begin
            state_nxt = FULL;
            ld1_new   = 1'b1;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_nxt = ONE;
            ld0_shift = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Entry 0 is always the head; entry 1 only ever fills from FULL transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0_instr <= '0;
      e0_pc4   <= '0;
      e1_instr <= '0;
      e1_pc4   <= '0;
    end else begin
      if (ld0_new) begin
        e0_instr <= bus.in_instr;
        e0_pc4   <= bus.in_pc4;
      end else if (ld0_shift) begin
        e0_instr <= e1_instr;
        e0_pc4   <= e1_pc4;
      end
      if (ld1_new) begin
        e1_instr <= bus.in_instr;
        e1_pc4   <= bus.in_pc4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.stall_cnt <= '0;
    end else if (stall_inc && (bus.stall_cnt != {CNT_W{1'b1}})) begin
      bus.stall_cnt <= bus.stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Gating the head forces every derived field to zero while nothing is valid.
  assign head_instr = bus.out_valid ? e0_instr : '0;
  assign head_pc4   = bus.out_valid ? e0_pc4   : '0;

  assign bus.out_instr   = head_instr;
  assign bus.out_pc4     = head_pc4;
  assign bus.opcode      = head_instr[31:26];
  assign bus.rs          = head_instr[25:21];
  assign bus.rt          = head_instr[20:16];
  assign bus.rd          = head_instr[15:11];
  assign bus.shamt       = head_instr[10:6];
  assign bus.funct       = head_instr[5:0];
  assign bus.imm_sext    = {{(DATA_W-16){head_instr[15]}}, head_instr[15:0]};
  assign bus.jump_target = {head_pc4[DATA_W-1 -: 4], head_instr[25:0], 2'b00};

endmodule

// File: tb/tb_if_id_stage.sv
// Directed vector bench for if_id_stage; stall counter narrowed to 4 bits so saturation is reachable.
module tb_if_id_stage;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int NV     = 28;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  if_id_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  if_id_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [5:0]  e_op;
    logic [4:0]  e_rs;
    logic [4:0]  e_rt;
    logic [4:0]  e_rd;
    logic [4:0]  e_sh;
    logic [5:0]  e_fn;
    logic [31:0] e_imm;
    logic [31:0] e_jt;
    logic [3:0]  e_st;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(input logic [31:0] iv, input logic [31:0] instr, input logic [31:0] pc4,
                              input logic [31:0] ordy, input logic [31:0] fl,
                              input logic [31:0] ov, input logic [31:0] ir,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input logic [31:0] op, input logic [31:0] rs_v, input logic [31:0] rt_v,
                              input logic [31:0] rd_v, input logic [31:0] sh, input logic [31:0] fn,
                              input logic [31:0] imm, input logic [31:0] jt, input logic [31:0] st);
    vec_t v;
    v.iv = iv[0]; v.instr = instr; v.pc4 = pc4; v.ordy = ordy[0]; v.fl = fl[0];
    v.e_ov = ov[0]; v.e_ir = ir[0]; v.e_instr = e_instr; v.e_pc4 = e_pc4;
    v.e_op = op[5:0]; v.e_rs = rs_v[4:0]; v.e_rt = rt_v[4:0]; v.e_rd = rd_v[4:0];
    v.e_sh = sh[4:0]; v.e_fn = fn[5:0]; v.e_imm = imm; v.e_jt = jt; v.e_st = st[3:0];
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] instr, input logic [31:0] pc4,
                       input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_instr  = instr;
    bus.in_pc4    = pc4;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Test 1: reset, single load beat
    vt[0]  = mk(1, 32'h8C220004, 32'h00400004, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 0, 0, 1, 0, 1, 1, 32'h8C220004, 32'h00400004, 32'h23, 1, 2, 0, 0, 32'h04, 32'h4, 32'h00880010, 0);
    vt[2]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Test 2: R-type then negative immediate, back-to-back
    vt[3]  = mk(1, 32'h00221820, 32'h00400008, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(1, 32'h2021FFFC, 32'h0040000C, 1, 0, 1, 1, 32'h00221820, 32'h00400008, 0, 1, 2, 3, 0, 32'h20, 32'h1820, 32'h00886080, 0);
    vt[5]  = mk(0, 0, 0, 1, 0, 1, 1, 32'h2021FFFC, 32'h0040000C, 32'h08, 1, 1, 31, 31, 32'h3C, 32'hFFFFFFFC, 32'h0087FFF0, 0);
    vt[6]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Test 3: backpressure, A/B skid, C held by fetch
    vt[7]  = mk(1, 1, 32'h100, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[8]  = mk(1, 2, 32'h104, 0, 0, 1, 1, 1, 32'h100, 0, 0, 0, 0, 0, 1, 1, 4, 0);
    vt[9]  = mk(1, 3, 32'h108, 0, 0, 1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 1, 4, 1);
    vt[10] = mk(1, 3, 32'h108, 0, 0, 1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 1, 4, 2);
    vt[11] = mk(1, 3, 32'h108, 1, 0, 1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 1, 4, 3);
    vt[12] = mk(1, 3, 32'h108, 1, 0, 1, 1, 2, 32'h104, 0, 0, 0, 0, 0, 2, 2, 8, 3);
    vt[13] = mk(0, 0, 0, 1, 0, 1, 1, 3, 32'h108, 0, 0, 0, 0, 0, 3, 3, 32'hC, 3);
    vt[14] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    // Test 4: jump target upper nibble comes from pc4
    vt[15] = mk(1, 32'h08000010, 32'h00400004, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    vt[16] = mk(1, 32'h08000010, 32'hF0000004, 1, 0, 1, 1, 32'h08000010, 32'h00400004, 2, 0, 0, 0, 0, 32'h10, 32'h10, 32'h40, 3);
    vt[17] = mk(0, 0, 0, 1, 0, 1, 1, 32'h08000010, 32'hF0000004, 2, 0, 0, 0, 0, 32'h10, 32'h10, 32'hF0000040, 3);
    vt[18] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    // Test 5: flush from FULL, then flush from ONE with in_ready=1
    vt[19] = mk(1, 5, 32'h110, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    vt[20] = mk(1, 6, 32'h114, 0, 0, 1, 1, 5, 32'h110, 0, 0, 0, 0, 0, 5, 5, 32'h14, 3);
    vt[21] = mk(0, 0, 0, 0, 0, 1, 0, 5, 32'h110, 0, 0, 0, 0, 0, 5, 5, 32'h14, 4);
    vt[22] = mk(1, 7, 32'h118, 0, 1, 1, 0, 5, 32'h110, 0, 0, 0, 0, 0, 5, 5, 32'h14, 5);
    vt[23] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    vt[24] = mk(1, 9, 32'h11C, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    vt[25] = mk(1, 32'hA, 32'h120, 0, 1, 1, 1, 9, 32'h11C, 0, 0, 0, 0, 0, 9, 9, 32'h24, 5);
    vt[26] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    vt[27] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);

    #1;
    chk("rst_out_valid", -1, {31'b0, bus.out_valid}, 32'h0);
    chk("rst_in_ready", -1, {31'b0, bus.in_ready}, 32'h1);
    chk("rst_stall_cnt", -1, {28'b0, bus.stall_cnt}, 32'h0);
    chk("rst_out_instr", -1, bus.out_instr, 32'h0);

    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].iv, vt[i].instr, vt[i].pc4, vt[i].ordy, vt[i].fl);
      #1;
      chk("out_valid",   i, {31'b0, bus.out_valid}, {31'b0, vt[i].e_ov});
      chk("in_ready",    i, {31'b0, bus.in_ready},  {31'b0, vt[i].e_ir});
      chk("out_instr",   i, bus.out_instr,          vt[i].e_instr);
      chk("out_pc4",     i, bus.out_pc4,            vt[i].e_pc4);
      chk("opcode",      i, {26'b0, bus.opcode},    {26'b0, vt[i].e_op});
      chk("rs",          i, {27'b0, bus.rs},        {27'b0, vt[i].e_rs});
      chk("rt",          i, {27'b0, bus.rt},        {27'b0, vt[i].e_rt});
      chk("rd",          i, {27'b0, bus.rd},        {27'b0, vt[i].e_rd});
      chk("shamt",       i, {27'b0, bus.shamt},     {27'b0, vt[i].e_sh});
      chk("funct",       i, {26'b0, bus.funct},     {26'b0, vt[i].e_fn});
      chk("imm_sext",    i, bus.imm_sext,           vt[i].e_imm);
      chk("jump_target", i, bus.jump_target,        vt[i].e_jt);
      chk("stall_cnt",   i, {28'b0, bus.stall_cnt}, {28'b0, vt[i].e_st});
    end

    // Test 6: fill to FULL, then drop reset between edges
    @(negedge clk);
    drive(1'b1, 32'h21, 32'h300, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h22, 32'h304, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("pre_arst_in_ready", 100, {31'b0, bus.in_ready}, 32'h0);
    chk("pre_arst_stall", 100, {28'b0, bus.stall_cnt}, 32'h6);
    chk("pre_arst_instr", 100, bus.out_instr, 32'h21);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 101, {31'b0, bus.out_valid}, 32'h0);
    chk("arst_in_ready", 101, {31'b0, bus.in_ready}, 32'h1);
    chk("arst_stall", 101, {28'b0, bus.stall_cnt}, 32'h0);
    chk("arst_out_instr", 101, bus.out_instr, 32'h0);
    chk("arst_out_pc4", 101, bus.out_pc4, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h23, 32'h308, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("post_arst_valid", 102, {31'b0, bus.out_valid}, 32'h1);
    chk("post_arst_instr", 102, bus.out_instr, 32'h23);
    chk("post_arst_pc4", 102, bus.out_pc4, 32'h308);
    @(negedge clk);
    #1;
    chk("post_arst_drain", 103, {31'b0, bus.out_valid}, 32'h0);

    // Long stall: counter saturates, head held stable, then drains in order
    @(negedge clk);
    drive(1'b1, 32'h31, 32'h400, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h32, 32'h404, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    chk("sat_stall", 104, {28'b0, bus.stall_cnt}, 32'hF);
    chk("sat_hold_instr", 104, bus.out_instr, 32'h31);
    chk("sat_hold_pc4", 104, bus.out_pc4, 32'h400);
    chk("sat_in_ready", 104, {31'b0, bus.in_ready}, 32'h0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("sat_drain_b", 105, bus.out_instr, 32'h32);
    chk("sat_after", 105, {28'b0, bus.stall_cnt}, 32'hF);
    @(negedge clk);
    #1;
    chk("sat_empty", 106, {31'b0, bus.out_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
